// File: rtl/rxrbcnt_rd_ctrl.sv
// Receive-side read sequencer: pops one byte-count word per packet, then streams the matching
// data-FIFO words out on AXI-Stream with tkeep/tlast, or drains and drops flagged-bad packets.
module rxrbcnt_rd_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 16,
  localparam int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cnt_rdempty,
  output logic              cnt_rden,
  input  logic [31:0]       cnt_dataout,
  input  logic              dat_rdempty,
  output logic              dat_rden,
  input  logic [DATA_W-1:0] dat_dataout,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              pkt_done,
  output logic              pkt_drop,
  output logic              err_zero_len
);

  localparam int unsigned KeepLog = $clog2(KEEP_W);

  typedef enum logic [2:0] {StIdle, StCntRd, StCntLat, StXfer, StDrop} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [KEEP_W-1:0] keep_last_q, keep_last_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              pkt_drop_q, pkt_drop_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [DATA_W-1:0] buf_data_d [2];
  logic [KEEP_W-1:0] buf_keep_q [2];
  logic [KEEP_W-1:0] buf_keep_d [2];
  logic              buf_last_q [2];
  logic              buf_last_d [2];

  logic [LEN_W-1:0]   len;
  logic [LEN_W:0]     len_round;
  logic [LEN_W-1:0]   beats_calc;
  logic [KeepLog-1:0] rem;
  logic [KEEP_W-1:0]  keep_calc;
  logic [KEEP_W-1:0]  in_keep;
  logic               from_buf, tvalid, out_last, accept, push, pop;
  logic [2:0]         occ;
  logic               can_issue, rd_xfer, rd_drop;
  logic [1:0]         count_tmp;
  logic               unused_cnt_bits;

  assign len        = cnt_dataout[LEN_W-1:0];
  assign len_round  = {1'b0, len} + (LEN_W+1)'(KEEP_W - 1);
  assign beats_calc = LEN_W'(len_round >> KeepLog);
  assign rem        = len[KeepLog-1:0];
  assign keep_calc  = (rem == '0) ? '1 : ~({KEEP_W{1'b1}} << rem);
  assign unused_cnt_bits = ^cnt_dataout[30:LEN_W];

  // Output comes from the buffer head, or straight from the FIFO word arriving this cycle.
  assign from_buf = (count_q != 2'd0);
  assign tvalid   = from_buf | infl_q;
  assign in_keep  = infl_last_q ? keep_last_q : '1;
  assign out_last = from_buf ? buf_last_q[0] : infl_last_q;
  assign accept   = tvalid & m_axis_tready;
  assign push     = infl_q & ~(accept & ~from_buf);
  assign pop      = accept & from_buf;

  assign m_axis_tvalid = tvalid;
  assign m_axis_tdata  = !tvalid ? '0 : (from_buf ? buf_data_q[0] : dat_dataout);
  assign m_axis_tkeep  = !tvalid ? '0 : (from_buf ? buf_keep_q[0] : in_keep);
  assign m_axis_tlast  = tvalid & out_last;
  assign busy          = (state_q != StIdle);
  assign pkt_drop      = pkt_drop_q;

  // Occupancy plus the read in flight may never exceed the two buffer entries.
  assign occ       = {1'b0, count_q} + {2'b00, infl_q};
  assign can_issue = accept ? (occ < 3'd3) : (occ < 3'd2);
  assign rd_xfer   = (state_q == StXfer) && (beats_q != '0) && !dat_rdempty && can_issue;
  assign rd_drop   = (state_q == StDrop) && (beats_q != '0) && !dat_rdempty;
  assign dat_rden  = rd_xfer | rd_drop;

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    keep_last_d  = keep_last_q;
    pkt_drop_d   = 1'b0;
    cnt_rden     = 1'b0;
    pkt_done     = 1'b0;
    err_zero_len = 1'b0;
    infl_d       = rd_xfer;
    infl_last_d  = rd_xfer & (beats_q == LEN_W'(1));

    unique case (state_q)
      StIdle: begin
        if (!cnt_rdempty) state_d = StCntRd;
      end
      StCntRd: begin
        cnt_rden = !cnt_rdempty;
        if (!cnt_rdempty) state_d = StCntLat;
      end
      StCntLat: begin
        if (len == '0) begin
          err_zero_len = 1'b1;
          state_d      = StIdle;
        end else begin
          beats_d     = beats_calc;
          keep_last_d = keep_calc;
          state_d     = cnt_dataout[31] ? StDrop : StXfer;
        end
      end
      StXfer: begin
        if (rd_xfer) beats_d = beats_q - LEN_W'(1);
        if (accept && out_last) begin
          pkt_done = 1'b1;
          state_d  = StIdle;
        end
      end
      StDrop: begin
        if (rd_drop) begin
          beats_d = beats_q - LEN_W'(1);
          if (beats_q == LEN_W'(1)) begin
            pkt_drop_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      buf_data_d[i] = buf_data_q[i];
      buf_keep_d[i] = buf_keep_q[i];
      buf_last_d[i] = buf_last_q[i];
    end
    count_tmp = count_q;
    if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_keep_d[0] = buf_keep_q[1];
      buf_last_d[0] = buf_last_q[1];
      count_tmp     = count_q - 2'd1;
    end
    if (push) begin
      buf_data_d[count_tmp[0]] = dat_dataout;
      buf_keep_d[count_tmp[0]] = in_keep;
      buf_last_d[count_tmp[0]] = infl_last_q;
    end
    count_d = count_tmp + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      beats_q     <= '0;
      keep_last_q <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      pkt_drop_q  <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_keep_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      keep_last_q <= keep_last_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      pkt_drop_q  <= pkt_drop_d;
      count_q     <= count_d;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= buf_data_d[i];
        buf_keep_q[i] <= buf_keep_d[i];
        buf_last_q[i] <= buf_last_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rxrbcnt_rd_ctrl.sv
// Bench for rxrbcnt_rd_ctrl: FIFO models, a beat scoreboard, a packet table and
// hand-written latency/overhead and mid-packet reset sequences.
module tb_rxrbcnt_rd_ctrl;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic [31:0] cw;
    int          nwords;
    int          beats;
    logic [7:0]  klast;
    int          done;
    int          drop;
    int          zerr;
    bit          stress;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cnt_rdempty, cnt_rden, dat_rdempty, dat_rden;
  logic [31:0] cnt_dataout = '0;
  logic [63:0] dat_dataout = '0;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        busy, pkt_done, pkt_drop, err_zero_len;

  rxrbcnt_rd_ctrl #(.DATA_W(64), .LEN_W(16)) dut (
    .clk(clk), .reset(reset),
    .cnt_rdempty(cnt_rdempty), .cnt_rden(cnt_rden), .cnt_dataout(cnt_dataout),
    .dat_rdempty(dat_rdempty), .dat_rden(dat_rden), .dat_dataout(dat_dataout),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .pkt_done(pkt_done), .pkt_drop(pkt_drop), .err_zero_len(err_zero_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models with one-cycle read latency
  logic [31:0] cmem [0:63];
  logic [63:0] dmem [0:255];
  int cwr = 0, crd = 0, dwr = 0, drd = 0;
  bit stall_e = 1'b0;
  bit flush = 1'b0;

  assign cnt_rdempty = (cwr == crd);
  assign dat_rdempty = (dwr == drd) || stall_e;

  always @(posedge clk) begin
    if (flush) drd <= dwr;
    else if (dat_rden) begin
      dat_dataout <= dmem[drd % 256];
      drd <= drd + 1;
    end
    if (cnt_rden) begin
      cnt_dataout <= cmem[crd % 64];
      crd <= crd + 1;
    end
  end

  // Monitor: event counters, protocol violations, captured beats
  int n_cnt_rden = 0, n_dat_rden = 0, n_done = 0, n_drop = 0, n_zerr = 0, n_beats = 0;
  int viol_empty = 0, viol_stable = 0, viol_keep = 0, viol_out = 0;
  int out_cnt = 0;
  bit out_en = 1'b0;
  bit prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t got [0:1023];
  int got_wr = 0;

  always @(negedge clk) begin
    if (cnt_rden) n_cnt_rden <= n_cnt_rden + 1;
    if (dat_rden) n_dat_rden <= n_dat_rden + 1;
    if (pkt_done) n_done <= n_done + 1;
    if (pkt_drop) n_drop <= n_drop + 1;
    if (err_zero_len) n_zerr <= n_zerr + 1;
    if ((dat_rden && dat_rdempty) || (cnt_rden && cnt_rdempty)) viol_empty <= viol_empty + 1;
    if (!m_axis_tvalid && m_axis_tkeep != 8'h00) viol_keep <= viol_keep + 1;
    if (prev_stall && (!m_axis_tvalid || prev_beat != {m_axis_tdata, m_axis_tkeep, m_axis_tlast}))
      viol_stable <= viol_stable + 1;
    prev_stall <= m_axis_tvalid && !m_axis_tready;
    prev_beat  <= {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (out_en) begin
      out_cnt <= out_cnt + int'(dat_rden) - int'(m_axis_tvalid && m_axis_tready);
      if (out_cnt + int'(dat_rden) - int'(m_axis_tvalid && m_axis_tready) > 2)
        viol_out <= viol_out + 1;
    end else out_cnt <= 0;
    if (m_axis_tvalid && m_axis_tready) begin
      n_beats <= n_beats + 1;
      got[got_wr % 1024] <= {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      got_wr <= got_wr + 1;
    end
  end

  int total = 0, passed = 0;
  int got_rd = 0;
  beat_t expq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pop captured output beats against the expected queue
  task automatic sb_drain(input string tag);
    beat_t b, e;
    while (got_rd < got_wr) begin
      b = got[got_rd % 1024];
      got_rd++;
      if (expq.size() == 0) check({tag, " extra beat"}, 64'd1, 64'd0);
      else begin
        e = expq.pop_front();
        check({tag, " tdata"}, b.d, e.d);
        check({tag, " tkeep/tlast"}, {b.k, b.l}, {e.k, e.l});
      end
    end
  endtask

  task automatic load_pkt(input logic [31:0] cw, input int nwords, input logic [7:0] klast,
                          input bit good);
    logic [63:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = {$urandom, $urandom};
      dmem[dwr % 256] = w;
      dwr++;
      if (good) expq.push_back({w, (i == nwords - 1) ? klast : 8'hFF, i == nwords - 1});
    end
    cmem[cwr % 64] = cw;
    cwr++;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int b_cnt, b_dat, b_done, b_drop, b_zerr, b_beats, k;
    bit fin;
    b_cnt = n_cnt_rden; b_dat = n_dat_rden; b_done = n_done;
    b_drop = n_drop; b_zerr = n_zerr; b_beats = n_beats;
    @(posedge clk); #1;
    out_en = v.stress;
    load_pkt(v.cw, v.nwords, v.klast, (v.done != 0));
    fin = 1'b0;
    k = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk); #1;
      if (v.stress) begin
        m_axis_tready = (k % 4 == 0) || (k % 4 == 3);
        stall_e = (k % 2 == 1);
        k++;
      end
      fin = ((n_done + n_drop + n_zerr) > (b_done + b_drop + b_zerr)) && !busy;
    end
    if (!fin) check({tag, " completion timeout"}, 64'd0, 64'd1);
    m_axis_tready = 1'b1;
    stall_e = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_en = 1'b0;
    check({tag, " beats"}, n_beats - b_beats, v.beats);
    check({tag, " pkt_done"}, n_done - b_done, v.done);
    check({tag, " pkt_drop"}, n_drop - b_drop, v.drop);
    check({tag, " err_zero_len"}, n_zerr - b_zerr, v.zerr);
    check({tag, " cnt_rden"}, n_cnt_rden - b_cnt, 1);
    check({tag, " dat_rden"}, n_dat_rden - b_dat, v.nwords);
    sb_drain(tag);
    check({tag, " scoreboard empty"}, expq.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ctrl outputs"},
          {cnt_rden, dat_rden, m_axis_tvalid, m_axis_tlast, busy, pkt_done, pkt_drop,
           err_zero_len}, 8'h00);
    check({tag, " tdata"}, m_axis_tdata, 64'd0);
    check({tag, " tkeep"}, m_axis_tkeep, 8'h00);
  endtask

  vec_t tbl [8];

  initial begin
    int t0, tc, td, tv, fb, lb, dn, nd, acc, b_done, b_beats, b_cnt;
    bit ok;
    tbl[0] = '{32'd64,         8, 8, 8'hFF, 1, 0, 0, 1'b0};
    tbl[1] = '{32'd13,         2, 2, 8'h1F, 1, 0, 0, 1'b0};
    tbl[2] = '{32'd8,          1, 1, 8'hFF, 1, 0, 0, 1'b0};
    tbl[3] = '{32'h0000_0000,  0, 0, 8'h00, 0, 0, 1, 1'b0};
    tbl[4] = '{32'd16,         2, 2, 8'hFF, 1, 0, 0, 1'b0};
    tbl[5] = '{32'h8000_0014,  3, 0, 8'h00, 0, 1, 0, 1'b0};
    tbl[6] = '{32'd21,         3, 3, 8'h1F, 1, 0, 0, 1'b0};
    tbl[7] = '{32'd40,         5, 5, 8'hFF, 1, 0, 0, 1'b1};

    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Latency, sustained throughput and inter-packet overhead
    load_pkt(32'd64, 8, 8'hFF, 1'b1);
    load_pkt(32'd8, 1, 8'hFF, 1'b1);
    crd = crd;
    @(posedge clk); #1;
    cwr = cwr;
    tc = -1; td = -1; tv = -1; fb = -1; lb = -1; dn = -1; nd = -1; acc = 0;
    @(negedge clk);
    t0 = cyc - 1;
    for (int i = 0; i < 80; i++) begin
      if (cnt_rden && tc < 0) tc = cyc;
      if (dat_rden && td < 0) td = cyc;
      if (m_axis_tvalid && tv < 0) tv = cyc;
      if (m_axis_tvalid && m_axis_tready && acc < 8) begin
        if (fb < 0) fb = cyc;
        acc++;
        if (acc == 8) lb = cyc;
      end
      if (dat_rden && dn >= 0 && nd < 0 && cyc > dn) nd = cyc;
      if (pkt_done && dn < 0) dn = cyc;
      @(negedge clk);
    end
    check("lat cnt_rden", tc - t0, 1);
    check("lat dat_rden", td - t0, 3);
    check("lat tvalid", tv - t0, 4);
    check("throughput span", lb - fb, 7);
    check("overhead to next dat_rden", nd - dn, 4);
    sb_drain("timing");
    check("timing scoreboard empty", expq.size(), 0);

    // Reset asserted while beat 3 of a 64-byte packet is on the bus
    b_done = n_done; b_beats = n_beats;
    @(posedge clk); #1;
    load_pkt(32'd64, 8, 8'hFF, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk); #1;
      ok = (n_beats - b_beats >= 2);
    end
    if (!ok) check("reset wait timeout", 64'd0, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (4) @(posedge clk);
    #1;
    check("midreset pkt_done", n_done - b_done, 0);
    check("midreset beats", n_beats - b_beats, 3);
    sb_drain("midreset");
    expq.delete();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    b_cnt = n_cnt_rden;
    run_vec(tbl[2], "after reset");
    check("after reset single pop", n_cnt_rden - b_cnt, 1);

    check("rden while empty", viol_empty, 0);
    check("hold while stalled", viol_stable, 0);
    check("tkeep idle zero", viol_keep, 0);
    check("outstanding limit", viol_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
